train_sequencer: RTL
====================

Name: train_sequencer

Overview:
Training-loop controller for the hidden/output neuron datapath. It sequences the forward pass 0, forward pass 1, backward pass and weight-update phases for each sample, and counts samples and epochs. It stops on convergence (end check), on the epoch limit, on abort, or on a phase watchdog timeout. It sits between the top-level input pins and the neuron array, and drives the phase enables the datapath already consumes.

Parameters:
SAMPLE_W, 4, width of sample index
NUM_SAMPLES, 8, samples per epoch (1..2^SAMPLE_W)
EPOCH_W, 8, width of epoch counter
MAX_EPOCHS, 16, epoch limit (1..2^EPOCH_W-1)
WDT_W, 6, watchdog counter width; timeout when count reaches 2^WDT_W-1

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
en_i  in  1  global enable; low freezes all state, counters and outputs
start_i  in  1  start/restart request (level sampled each cycle)
abort_i  in  1  abort request
fwd0_done_i  in  1  hidden layer finished
fwd1_done_i  in  1  output layer/loss finished
bwd_done_i  in  1  backward pass finished
converged_i  in  1  end check from output neuron
f0_pass_o  out  1  high while in FWD0
f1_pass_o  out  1  high while in FWD1
b_pass_o  out  1  high while in BWD
upd_o  out  1  one-cycle weight-commit strobe
sample_idx_o  out  SAMPLE_W  current sample
epoch_o  out  EPOCH_W  completed epochs
busy_o  out  1  state not IDLE/DONE/ERR
done_o  out  1  high in DONE
timeout_o  out  1  high in ERR
state_o  out  3  encoded state

Behaviour:
- States, with state_o encoding: IDLE=0, FWD0=1, FWD1=2, BWD=3, UPD=4, NEXT=5, DONE=6, ERR=7.
- Reset: state=IDLE; sample=0, epoch=0, watchdog=0; all outputs 0.
- All outputs are Moore decodes of the registered state and counters. A phase output rises the cycle after the transition into its state.
- en_i=0: no register changes, including the watchdog. Outputs hold.
- Priority when en_i=1: abort_i first, then done inputs, then the watchdog, then start_i.
- abort_i: from any state, the next state is IDLE. Counters are not cleared. abort_i with start_i in IDLE stays in IDLE.
- IDLE/DONE/ERR + start_i: go to FWD0. Clear sample, epoch and watchdog.
- FWD0: fwd0_done_i goes to FWD1.
- FWD1: fwd1_done_i goes to BWD.
- BWD: bwd_done_i goes to UPD.
- UPD: upd_o=1 for exactly one cycle, then NEXT.
- NEXT, one cycle:
  - If sample==NUM_SAMPLES-1: sample wraps to 0 and epoch increments. Then, if converged_i=1 or the new epoch==MAX_EPOCHS, go to DONE; otherwise go to FWD0.
  - Otherwise: sample increments and the next state is FWD0 (converged_i is ignored mid-epoch).
- Done inputs are ignored outside their own phase state.
- Watchdog:
  - Cleared on every entry to FWD0, FWD1 or BWD.
  - Increments each enabled cycle while in one of those states and the phase's done input is low.
  - When it reaches 2^WDT_W-1, the next state is ERR.
  - If the done input arrives in that same cycle, done wins.
- DONE and ERR hold until start_i or abort_i. epoch_o and sample_idx_o keep their final values there.
- Counters saturate-free: epoch never exceeds MAX_EPOCHS because DONE is forced.
- rst_i asserted mid-phase: immediate asynchronous return to the reset values.

Optional Feature:
Macro TRAIN_SEQ_INFER_EN.
- Defined: adds input port infer_i (1 bit), sampled and latched on the start_i transition.
  - When the latch is set, FWD1 completion goes directly to NEXT, skipping BWD and UPD; upd_o never asserts and b_pass_o stays 0.
  - The epoch limit and converged_i handling are unchanged.
  - The latch clears on reset.
- Undefined: no infer_i port; the full training sequence is always used.

Test Plan:
- Reset, then start_i pulse, with each done input asserted 2 cycles after its phase rises, converged_i=0, MAX_EPOCHS=2 -> phase order f0,f1,b,upd repeats 16 times. sample_idx_o runs 0..7 twice, epoch_o ends at 2, done_o=1, 16 upd_o pulses.
- converged_i=1 held, NUM_SAMPLES=8 -> DONE after the first epoch (epoch_o=1, 8 upd_o pulses). converged_i asserted at sample 3 has no effect until the epoch boundary.
- Withhold fwd1_done_i, WDT_W=6 -> FWD1 for 63 cycles, then state_o=7, timeout_o=1. Same test with fwd1_done_i on cycle 63 -> BWD, no timeout.
- abort_i in BWD at sample 5 -> IDLE next cycle, sample_idx_o=5, all phase outputs 0. Then start_i -> FWD0 with sample 0, epoch 0.
- en_i low for 10 cycles mid-FWD0 with the done input high -> state, watchdog and outputs frozen; FWD1 is entered the first enabled cycle. Separately, rst_i mid-UPD -> all outputs 0 asynchronously.
- With TRAIN_SEQ_INFER_EN defined, infer_i=1 at start -> sequence f0,f1,NEXT only, zero upd_o pulses, epoch_o reaches MAX_EPOCHS.

Source files
------------

// File: rtl/train_sequencer.sv
// rtl/train_sequencer.sv - training-loop phase sequencer with sample/epoch counters and phase watchdog
// Optional TRAIN_SEQ_INFER_EN: adds infer_i, latched at start, for forward-only (inference) runs.
module train_sequencer #(
   parameter int SAMPLE_W    = 4,
   parameter int NUM_SAMPLES = 8,
   parameter int EPOCH_W     = 8,
   parameter int MAX_EPOCHS  = 16,
   parameter int WDT_W       = 6
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic                start_i,
   input  logic                abort_i,
`ifdef TRAIN_SEQ_INFER_EN
   input  logic                infer_i,
`endif
   input  logic                fwd0_done_i,
   input  logic                fwd1_done_i,
   input  logic                bwd_done_i,
   input  logic                converged_i,
   output logic                f0_pass_o,
   output logic                f1_pass_o,
   output logic                b_pass_o,
   output logic                upd_o,
   output logic [SAMPLE_W-1:0] sample_idx_o,
   output logic [EPOCH_W-1:0]  epoch_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                timeout_o,
   output logic [2:0]          state_o
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_FWD0 = 3'd1;
   localparam logic [2:0] S_FWD1 = 3'd2;
   localparam logic [2:0] S_BWD  = 3'd3;
   localparam logic [2:0] S_UPD  = 3'd4;
   localparam logic [2:0] S_NEXT = 3'd5;
   localparam logic [2:0] S_DONE = 3'd6;
   localparam logic [2:0] S_ERR  = 3'd7;

   localparam logic [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(NUM_SAMPLES - 1);
   localparam logic [EPOCH_W-1:0]  EPOCH_LIMIT = EPOCH_W'(MAX_EPOCHS);
   // Expiry is judged on the cycle whose increment would reach 2^WDT_W-1.
   localparam logic [WDT_W-1:0]    WDT_PRE     = WDT_W'((2 ** WDT_W) - 2);

   logic [2:0]          r_state;
   logic [2:0]          w_next;
   logic [SAMPLE_W-1:0] r_sample;
   logic [EPOCH_W-1:0]  r_epoch;
   logic [EPOCH_W-1:0]  w_epoch_inc;
   logic [WDT_W-1:0]    r_wdt;
   logic                w_in_phase;
   logic                w_wdt_expire;
   logic                w_last_sample;
   logic                w_restart;
   logic                w_infer;

   assign w_in_phase    = (r_state == S_FWD0) || (r_state == S_FWD1) || (r_state == S_BWD);
   assign w_wdt_expire  = w_in_phase && (r_wdt == WDT_PRE);
   assign w_last_sample = (r_sample == LAST_SAMPLE);
   assign w_epoch_inc   = r_epoch + 1'b1;
   assign w_restart     = en_i && !abort_i && start_i &&
                          ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

`ifdef TRAIN_SEQ_INFER_EN
   logic r_infer;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_infer <= 1'b0;
      end else if (w_restart) begin
         r_infer <= infer_i;
      end
   end

   assign w_infer = r_infer;
`else
   assign w_infer = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else if (en_i) begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (en_i) begin
         if (abort_i) begin
            w_next = S_IDLE;
         end else begin
            case (r_state)
               S_IDLE, S_DONE, S_ERR: begin
                  if (start_i) w_next = S_FWD0;
               end
               S_FWD0: begin
                  if (fwd0_done_i)       w_next = S_FWD1;
                  else if (w_wdt_expire) w_next = S_ERR;
               end
               S_FWD1: begin
                  if (fwd1_done_i)       w_next = w_infer ? S_NEXT : S_BWD;
                  else if (w_wdt_expire) w_next = S_ERR;
               end
               S_BWD: begin
                  if (bwd_done_i)        w_next = S_UPD;
                  else if (w_wdt_expire) w_next = S_ERR;
               end
               S_UPD: begin
                  w_next = S_NEXT;
               end
               S_NEXT: begin
                  // Convergence is only honoured at the epoch boundary.
                  if (w_last_sample && (converged_i || (w_epoch_inc == EPOCH_LIMIT)))
                     w_next = S_DONE;
                  else
                     w_next = S_FWD0;
               end
               default: begin
                  w_next = S_IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sample <= '0;
         r_epoch  <= '0;
         r_wdt    <= '0;
      end else if (en_i) begin
         if (w_restart) begin
            r_sample <= '0;
            r_epoch  <= '0;
         end else if ((r_state == S_NEXT) && !abort_i) begin
            if (w_last_sample) begin
               r_sample <= '0;
               r_epoch  <= w_epoch_inc;
            end else begin
               r_sample <= r_sample + 1'b1;
            end
         end
         // Any state change clears the watchdog, covering every phase entry.
         if (w_next != r_state) begin
            r_wdt <= '0;
         end else if (w_in_phase) begin
            r_wdt <= r_wdt + 1'b1;
         end
      end
   end

   always_comb begin
      f0_pass_o = (r_state == S_FWD0);
      f1_pass_o = (r_state == S_FWD1);
      b_pass_o  = (r_state == S_BWD);
      upd_o     = (r_state == S_UPD);
      busy_o    = (r_state == S_FWD0) || (r_state == S_FWD1) || (r_state == S_BWD) ||
                  (r_state == S_UPD)  || (r_state == S_NEXT);
      done_o    = (r_state == S_DONE);
      timeout_o = (r_state == S_ERR);
   end

   assign sample_idx_o = r_sample;
   assign epoch_o      = r_epoch;
   assign state_o      = r_state;

endmodule
